muldiv_share_arbiter: RTL and testbench

- Shares the coprocessor's single RV32M multiply/divide unit between two requesters: requester 0 is the CPU execute stage, requester 1 is a debug/accelerator port.
- Arbitrates round-robin and builds the MULDIV instruction word for the granted request.
- Holds the instruction and operands stable on the coprocessor interface until a result is captured.
- Returns the result to the winning requester through a valid/ready response handshake, with a timeout guard.

---
 rtl/muldiv_share_arbiter.sv | 216 +++++++++++++++++++++
 tb/tb_muldiv_share_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_share_arbiter.sv
// -----------------------------------------------------------------------------
// muldiv_share_arbiter
//
// Shares one RV32M multiply/divide coprocessor between two requesters
// (0 = CPU execute stage, 1 = debug/accelerator port). A round-robin pick
// grants one request at a time. The arbiter builds the OP/MULDIV instruction
// word and holds it, with the operands, on the coprocessor interface until a
// result arrives or the timeout expires. The result goes back to the winner
// through a valid/ready response handshake.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid/ready     per-requester request handshake (ready = grant)
//   req_funct3          packed funct3, requester i uses [3i+2:3i]
//   req_rs1/req_rs2     packed operands, requester i uses [DW*i +: DW]
//   resp_valid/ready    per-requester response handshake
//   resp_data/resp_err  result for the responding requester, err = timeout
//   cp_instruction      instruction word to the coprocessor (0 when idle)
//   cp_rs1/rs2_data     operands to the coprocessor
//   cp_result(_valid)   result from the coprocessor
//   cp_stall            coprocessor busy indication
//   busy                high whenever the arbiter is not IDLE
// -----------------------------------------------------------------------------
module muldiv_share_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TMR_W          = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [5:0]              req_funct3,
  input  logic [2*DATA_WIDTH-1:0] req_rs1,
  input  logic [2*DATA_WIDTH-1:0] req_rs2,
  output logic [1:0]              resp_valid,
  input  logic [1:0]              resp_ready,
  output logic [DATA_WIDTH-1:0]   resp_data,
  output logic                    resp_err,
  output logic [31:0]             cp_instruction,
  output logic [DATA_WIDTH-1:0]   cp_rs1_data,
  output logic [DATA_WIDTH-1:0]   cp_rs2_data,
  input  logic [DATA_WIDTH-1:0]   cp_result,
  input  logic                    cp_result_valid,
  input  logic                    cp_stall,
  output logic                    busy
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RESP  = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_next_state;

  logic                  r_last_grant;
  logic                  r_id;
  logic [TMR_W-1:0]      r_timer;
  logic [31:0]           r_cp_instruction;
  logic [DATA_WIDTH-1:0] r_cp_rs1;
  logic [DATA_WIDTH-1:0] r_cp_rs2;
  logic [1:0]            r_resp_valid;
  logic [DATA_WIDTH-1:0] r_resp_data;
  logic                  r_resp_err;
  logic                  r_busy;

  logic                  w_sel_id;
  logic                  w_accept;
  logic                  w_timeout;
  logic [2:0]            w_sel_funct3;
  logic [DATA_WIDTH-1:0] w_sel_rs1;
  logic [DATA_WIDTH-1:0] w_sel_rs2;

  // R-type OP opcode with funct7=0000001 selects the M-extension group.
  function automatic logic [31:0] build_muldiv(input logic [2:0] funct3);
    return {7'b0000001, 10'b0000000000, funct3, 5'b00000, 7'b0110011};
  endfunction

  // Round-robin pick: a lone requester wins; on a conflict the one not
  // granted last time wins.
  always_comb begin
    w_sel_id  = 1'b0;
    req_ready = 2'b00;
    if (req_valid == 2'b11) begin
      w_sel_id = ~r_last_grant;
    end else if (req_valid == 2'b10) begin
      w_sel_id = 1'b1;
    end else begin
      w_sel_id = 1'b0;
    end
    if ((r_state == ST_IDLE) && (req_valid != 2'b00)) begin
      req_ready = w_sel_id ? 2'b10 : 2'b01;
    end else begin
      req_ready = 2'b00;
    end
  end

  assign w_accept     = (req_ready != 2'b00);
  assign w_timeout    = (r_timer == TMR_W'(TIMEOUT_CYCLES - 1));
  assign w_sel_funct3 = w_sel_id ? req_funct3[5:3] : req_funct3[2:0];
  assign w_sel_rs1    = w_sel_id ? req_rs1[2*DATA_WIDTH-1:DATA_WIDTH] : req_rs1[DATA_WIDTH-1:0];
  assign w_sel_rs2    = w_sel_id ? req_rs2[2*DATA_WIDTH-1:DATA_WIDTH] : req_rs2[DATA_WIDTH-1:0];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; a result arriving together with the timeout wins.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_next_state = ST_ISSUE;
        else          w_next_state = ST_IDLE;
      end
      ST_ISSUE: begin
        w_next_state = ST_WAIT;
      end
      ST_WAIT: begin
        if (cp_result_valid || w_timeout) w_next_state = ST_RESP;
        else                              w_next_state = ST_WAIT;
      end
      ST_RESP: begin
        if (resp_ready[r_id]) w_next_state = ST_DRAIN;
        else                  w_next_state = ST_RESP;
      end
      ST_DRAIN: begin
        // Wait out any stall left over so it cannot leak into the next grant.
        if (!cp_stall) w_next_state = ST_IDLE;
        else           w_next_state = ST_DRAIN;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Datapath: grant latch, coprocessor drive, timer and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant     <= 1'b1;
      r_id             <= 1'b0;
      r_timer          <= '0;
      r_cp_instruction <= 32'h0000_0000;
      r_cp_rs1         <= '0;
      r_cp_rs2         <= '0;
      r_resp_valid     <= 2'b00;
      r_resp_data      <= '0;
      r_resp_err       <= 1'b0;
      r_busy           <= 1'b0;
    end else begin
      r_busy <= (w_next_state != ST_IDLE);
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            // Loaded here so the registered outputs are valid during ISSUE.
            r_id             <= w_sel_id;
            r_last_grant     <= w_sel_id;
            r_cp_instruction <= build_muldiv(w_sel_funct3);
            r_cp_rs1         <= w_sel_rs1;
            r_cp_rs2         <= w_sel_rs2;
          end
        end
        ST_ISSUE: begin
          r_timer <= '0;
        end
        ST_WAIT: begin
          r_timer <= r_timer + TMR_W'(1);
          if (cp_result_valid) begin
            r_resp_valid     <= r_id ? 2'b10 : 2'b01;
            r_resp_data      <= cp_result;
            r_resp_err       <= 1'b0;
            r_cp_instruction <= 32'h0000_0000;
          end else if (w_timeout) begin
            r_resp_valid     <= r_id ? 2'b10 : 2'b01;
            r_resp_data      <= '0;
            r_resp_err       <= 1'b1;
            r_cp_instruction <= 32'h0000_0000;
          end
        end
        ST_RESP: begin
          if (resp_ready[r_id]) begin
            r_resp_valid <= 2'b00;
            r_resp_data  <= '0;
            r_resp_err   <= 1'b0;
          end
        end
        ST_DRAIN: begin
          r_cp_instruction <= 32'h0000_0000;
        end
        default: begin
          r_cp_instruction <= 32'h0000_0000;
          r_resp_valid     <= 2'b00;
        end
      endcase
    end
  end

  assign cp_instruction = r_cp_instruction;
  assign cp_rs1_data    = r_cp_rs1;
  assign cp_rs2_data    = r_cp_rs2;
  assign resp_valid     = r_resp_valid;
  assign resp_data      = r_resp_data;
  assign resp_err       = r_resp_err;
  assign busy           = r_busy;

endmodule

// File: tb/tb_muldiv_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_muldiv_share_arbiter
//
// Directed bench for muldiv_share_arbiter. The coprocessor is modelled
// inline by each scenario: it answers with hand-computed results after a
// chosen number of cycles, or never answers, to reach the timeout.
// -----------------------------------------------------------------------------
module tb_muldiv_share_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [5:0]  req_funct3;
  logic [63:0] req_rs1;
  logic [63:0] req_rs2;
  logic [1:0]  resp_valid;
  logic [1:0]  resp_ready;
  logic [31:0] resp_data;
  logic        resp_err;
  logic [31:0] cp_instruction;
  logic [31:0] cp_rs1_data;
  logic [31:0] cp_rs2_data;
  logic [31:0] cp_result;
  logic        cp_result_valid;
  logic        cp_stall;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  muldiv_share_arbiter #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(16), .TMR_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
    .req_rs1(req_rs1), .req_rs2(req_rs2),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_err(resp_err),
    .cp_instruction(cp_instruction), .cp_rs1_data(cp_rs1_data), .cp_rs2_data(cp_rs2_data),
    .cp_result(cp_result), .cp_result_valid(cp_result_valid), .cp_stall(cp_stall),
    .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raise a request and hold it until granted (bounded); returns at ISSUE.
  task automatic do_request(input int id, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] b, output bit granted);
    granted = 1'b0;
    req_funct3[id*3 +: 3] = f3;
    req_rs1[id*32 +: 32]  = a;
    req_rs2[id*32 +: 32]  = b;
    req_valid[id]         = 1'b1;
    for (int i = 0; i < 40 && !granted; i++) begin
      #1;
      if (req_ready[id]) granted = 1'b1;
      @(posedge clk);
      #1;
    end
    req_valid[id] = 1'b0;
  endtask

  // Coprocessor answers on the next sampled edge.
  task automatic cp_reply(input logic [31:0] res);
    cp_result       = res;
    cp_result_valid = 1'b1;
    tick();
    cp_result_valid = 1'b0;
  endtask

  // Accept the response from RESP and return through DRAIN to IDLE.
  task automatic accept_resp(input int id);
    resp_ready[id] = 1'b1;
    tick();
    resp_ready[id] = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 2'b00; req_funct3 = 6'd0; req_rs1 = 64'd0; req_rs2 = 64'd0;
    resp_ready = 2'b00; cp_result = 32'd0; cp_result_valid = 1'b0; cp_stall = 1'b0;
    #12;
    n_tests++; if ({busy, resp_valid, resp_err, cp_instruction, cp_rs1_data, cp_rs2_data, resp_data} !== 132'd0) begin n_fail++; $display("FAIL reset_outputs got=%h exp=0", {busy, resp_valid, resp_err, cp_instruction, cp_rs1_data, cp_rs2_data, resp_data}); end
    n_tests++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_req_ready got=%b exp=00", req_ready); end
    @(posedge clk); #2; rst_n = 1'b1;
    tick();
  endtask

  task automatic test_conflict();
    req_funct3 = {3'b111, 3'b101};
    req_rs1 = {32'd100, 32'd100};
    req_rs2 = {32'd7, 32'd7};
    req_valid = 2'b11;
    #1;
    n_tests++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL conflict1_grant got=%b exp=01", req_ready); end
    tick(); req_valid[0] = 1'b0;
    n_tests++; if (cp_instruction !== 32'h0200_5033) begin n_fail++; $display("FAIL divu_instr got=%h exp=02005033", cp_instruction); end
    tick(); cp_reply(32'd14);
    n_tests++; if (resp_valid !== 2'b01 || resp_data !== 32'd14 || resp_err !== 1'b0) begin n_fail++; $display("FAIL divu_resp got=%b/%0d/%b exp=01/14/0", resp_valid, resp_data, resp_err); end
    n_tests++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL conflict_no_grant_in_resp got=%b exp=00", req_ready); end
    resp_ready[0] = 1'b1; tick(); resp_ready[0] = 1'b0;
    n_tests++; if (req_ready !== 2'b00 || busy !== 1'b1) begin n_fail++; $display("FAIL drain_no_grant got=%b/%b exp=00/1", req_ready, busy); end
    tick();
    n_tests++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL conflict2_grant got=%b exp=10", req_ready); end
    tick(); req_valid[1] = 1'b0;
    n_tests++; if (cp_instruction !== 32'h0200_7033 || cp_rs1_data !== 32'd100 || cp_rs2_data !== 32'd7) begin n_fail++; $display("FAIL remu_issue got=%h/%0d/%0d exp=02007033/100/7", cp_instruction, cp_rs1_data, cp_rs2_data); end
    tick(); cp_reply(32'd2);
    n_tests++; if (resp_valid !== 2'b10 || resp_data !== 32'd2) begin n_fail++; $display("FAIL remu_resp got=%b/%0d exp=10/2", resp_valid, resp_data); end
    accept_resp(1);
    req_valid = 2'b11;
    #1;
    n_tests++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL conflict3_grant got=%b exp=01", req_ready); end
    tick(); req_valid = 2'b00;
    tick(); cp_reply(32'd14);
    accept_resp(0);
  endtask

  task automatic test_mul();
    bit g;
    do_request(0, 3'b000, 32'd7, 32'd6, g);
    n_tests++; if (!g) begin n_fail++; $display("FAIL mul_grant got=0 exp=1"); end
    n_tests++; if (cp_instruction !== 32'h0200_0033 || cp_rs1_data !== 32'd7 || cp_rs2_data !== 32'd6 || busy !== 1'b1) begin n_fail++; $display("FAIL mul_issue got=%h/%0d/%0d/%b exp=02000033/7/6/1", cp_instruction, cp_rs1_data, cp_rs2_data, busy); end
    repeat (4) tick();
    n_tests++; if (cp_instruction !== 32'h0200_0033 || resp_valid !== 2'b00) begin n_fail++; $display("FAIL mul_wait_hold got=%h/%b exp=02000033/00", cp_instruction, resp_valid); end
    cp_reply(32'd42);
    n_tests++; if (resp_valid !== 2'b01 || resp_data !== 32'd42 || resp_err !== 1'b0 || cp_instruction !== 32'd0) begin n_fail++; $display("FAIL mul_resp got=%b/%0d/%b/%h exp=01/42/0/0", resp_valid, resp_data, resp_err, cp_instruction); end
    cp_stall = 1'b1;
    resp_ready[0] = 1'b1; tick(); resp_ready[0] = 1'b0;
    n_tests++; if (resp_valid !== 2'b00) begin n_fail++; $display("FAIL mul_resp_clear got=%b exp=00", resp_valid); end
    tick(); tick();
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL drain_stall_hold got=%b exp=1", busy); end
    cp_stall = 1'b0; tick();
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL drain_exit got=%b exp=0", busy); end
  endtask

  task automatic test_div0();
    bit g;
    do_request(1, 3'b100, 32'd123, 32'd0, g);
    n_tests++; if (!g) begin n_fail++; $display("FAIL div0_grant got=0 exp=1"); end
    req_rs2[63:32] = 32'd5;
    n_tests++; if (cp_instruction !== 32'h0200_4033 || cp_rs2_data !== 32'd0) begin n_fail++; $display("FAIL div0_issue got=%h/%0d exp=02004033/0", cp_instruction, cp_rs2_data); end
    repeat (3) tick();
    n_tests++; if (cp_rs2_data !== 32'd0 || cp_rs1_data !== 32'd123) begin n_fail++; $display("FAIL div0_operand_hold got=%0d/%0d exp=0/123", cp_rs2_data, cp_rs1_data); end
    cp_reply(32'hFFFF_FFFF);
    n_tests++; if (resp_valid !== 2'b10 || resp_data !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div0_resp got=%b/%h exp=10/ffffffff", resp_valid, resp_data); end
    resp_ready[0] = 1'b1; tick(); resp_ready[0] = 1'b0;
    n_tests++; if (resp_valid !== 2'b10) begin n_fail++; $display("FAIL other_ready_ignored got=%b exp=10", resp_valid); end
    accept_resp(1);
    n_tests++; if (resp_valid !== 2'b00 || busy !== 1'b0) begin n_fail++; $display("FAIL div0_done got=%b/%b exp=00/0", resp_valid, busy); end
  endtask

  task automatic test_timeout();
    bit g;
    do_request(0, 3'b000, 32'd3, 32'd4, g);
    cp_result = 32'd99;
    tick();
    repeat (15) tick();
    n_tests++; if (resp_valid !== 2'b00 || busy !== 1'b1) begin n_fail++; $display("FAIL timeout_early got=%b/%b exp=00/1", resp_valid, busy); end
    tick();
    n_tests++; if (resp_valid !== 2'b01 || resp_data !== 32'd0 || resp_err !== 1'b1) begin n_fail++; $display("FAIL timeout_resp got=%b/%0d/%b exp=01/0/1", resp_valid, resp_data, resp_err); end
    cp_reply(32'd99);
    n_tests++; if (resp_valid !== 2'b01 || resp_data !== 32'd0 || resp_err !== 1'b1) begin n_fail++; $display("FAIL late_result_ignored got=%b/%0d/%b exp=01/0/1", resp_valid, resp_data, resp_err); end
    accept_resp(0);
    n_tests++; if (resp_err !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL timeout_done got=%b/%b exp=0/0", resp_err, busy); end
    do_request(0, 3'b000, 32'd7, 32'd11, g);
    tick();
    repeat (15) tick();
    cp_reply(32'd77);
    n_tests++; if (resp_valid !== 2'b01 || resp_data !== 32'd77 || resp_err !== 1'b0) begin n_fail++; $display("FAIL result_beats_timeout got=%b/%0d/%b exp=01/77/0", resp_valid, resp_data, resp_err); end
    accept_resp(0);
  endtask

  task automatic test_hold();
    bit g;
    do_request(0, 3'b000, 32'd5, 32'd11, g);
    req_funct3[5:3] = 3'b000; req_rs1[63:32] = 32'd2; req_rs2[63:32] = 32'd3;
    req_valid[1] = 1'b1;
    tick(); cp_reply(32'd55);
    resp_ready[1] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_tests++; if (resp_valid !== 2'b01 || resp_data !== 32'd55 || req_ready !== 2'b00) begin n_fail++; $display("FAIL hold_cycle%0d got=%b/%0d/%b exp=01/55/00", i, resp_valid, resp_data, req_ready); end
      tick();
    end
    resp_ready[1] = 1'b0;
    accept_resp(0);
    n_tests++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL hold_next_grant got=%b exp=10", req_ready); end
    tick(); req_valid[1] = 1'b0;
    tick(); cp_reply(32'd6);
    n_tests++; if (resp_valid !== 2'b10 || resp_data !== 32'd6) begin n_fail++; $display("FAIL hold_r1_resp got=%b/%0d exp=10/6", resp_valid, resp_data); end
    accept_resp(1);
  endtask

  task automatic test_reset_mid();
    bit g;
    do_request(0, 3'b000, 32'd9, 32'd9, g);
    tick(); tick(); tick();
    #2; rst_n = 1'b0; #1;
    n_tests++; if ({busy, resp_valid, resp_err, cp_instruction, cp_rs1_data, cp_rs2_data, resp_data} !== 132'd0) begin n_fail++; $display("FAIL async_reset got=%h exp=0", {busy, resp_valid, resp_err, cp_instruction, cp_rs1_data, cp_rs2_data, resp_data}); end
    tick(); rst_n = 1'b1;
    cp_reply(32'd81);
    repeat (4) tick();
    n_tests++; if (resp_valid !== 2'b00 || busy !== 1'b0) begin n_fail++; $display("FAIL no_resp_after_reset got=%b/%b exp=00/0", resp_valid, busy); end
    req_funct3 = 6'b000_000; req_rs1 = {32'd8, 32'd2}; req_rs2 = {32'd8, 32'd3};
    req_valid = 2'b11;
    #1;
    n_tests++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL post_reset_grant got=%b exp=01", req_ready); end
    tick(); req_valid = 2'b00;
    n_tests++; if (cp_instruction !== 32'h0200_0033 || cp_rs1_data !== 32'd2) begin n_fail++; $display("FAIL post_reset_issue got=%h/%0d exp=02000033/2", cp_instruction, cp_rs1_data); end
    tick(); cp_reply(32'd6);
    n_tests++; if (resp_valid !== 2'b01 || resp_data !== 32'd6) begin n_fail++; $display("FAIL post_reset_resp got=%b/%0d exp=01/6", resp_valid, resp_data); end
    accept_resp(0);
  endtask

  initial begin
    test_reset();
    test_conflict();
    test_mul();
    test_div0();
    test_timeout();
    test_hold();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
